// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch with a single outstanding memory request,
// jump flush of in-flight data and a FIFO_DEPTH-entry instruction buffer.
module ifetch_unit #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [31:0] i_pc_addr,
    input  logic        i_jump_flag,
    output logic        o_hold_req,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_addr,
    input  logic        i_inst_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, WAIT_RSP, DISCARD} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   pend_q, pend_d;
    logic [31:0]   data_q [FIFO_DEPTH];
    logic [31:0]   addr_q [FIFO_DEPTH];
    logic          grant, push, pop;

    assign o_mem_req    = i_reset_n && state_q == IDLE && count_q < FULL && !i_jump_flag;
    assign o_mem_addr   = i_pc_addr;
    assign grant        = o_mem_req && i_mem_gnt;
    assign o_hold_req   = !grant;
    assign o_inst_valid = count_q != '0;
    assign o_inst       = o_inst_valid ? data_q[rd_q] : '0;
    assign o_inst_addr  = o_inst_valid ? addr_q[rd_q] : '0;
    // A jump kills both the response in flight and anything about to be popped
    assign push         = state_q == WAIT_RSP && i_mem_rvalid && !i_jump_flag;
    assign pop          = o_inst_valid && i_inst_ready && !i_jump_flag;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        case (state_q)
            IDLE: if (grant) begin
                state_d = WAIT_RSP;
                pend_d  = i_pc_addr;
            end
            WAIT_RSP: state_d = i_mem_rvalid ? IDLE : (i_jump_flag ? DISCARD : WAIT_RSP);
            DISCARD:  state_d = i_mem_rvalid ? IDLE : DISCARD;
            default:  state_d = IDLE;
        endcase
        if (i_jump_flag) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) wr_d = wr_q + 1'b1;
            if (pop) rd_d = rd_q + 1'b1;
            if (push && !pop) count_d = count_q + 1'b1;
            if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_clock) begin
        if (push) begin
            data_q[wr_q] <= i_mem_rdata;
            addr_q[wr_q] <= pend_q;
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed scenarios plus a randomized run against a
// queue-based reference model of the fetch unit.
module tb_ifetch_unit;
    localparam int DEPTH = 2;

    logic        i_clock = 0;
    logic        i_reset_n;
    logic [31:0] i_pc_addr;
    logic        i_jump_flag;
    logic        o_hold_req;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_addr;
    logic        i_inst_ready;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ifetch_unit #(.FIFO_DEPTH(DEPTH)) dut (
        .i_clock     (i_clock),
        .i_reset_n   (i_reset_n),
        .i_pc_addr   (i_pc_addr),
        .i_jump_flag (i_jump_flag),
        .o_hold_req  (o_hold_req),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr),
        .i_mem_gnt   (i_mem_gnt),
        .i_mem_rvalid(i_mem_rvalid),
        .i_mem_rdata (i_mem_rdata),
        .o_inst_valid(o_inst_valid),
        .o_inst      (o_inst),
        .o_inst_addr (o_inst_addr),
        .i_inst_ready(i_inst_ready)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_req"}, 32'(o_mem_req), 32'd0);
        check({tag, "_hold"}, 32'(o_hold_req), 32'd1);
        check({tag, "_valid"}, 32'(o_inst_valid), 32'd0);
        check({tag, "_inst"}, o_inst, 32'd0);
        check({tag, "_iaddr"}, o_inst_addr, 32'd0);
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_t        q[$];
        logic        m_out, m_flush, mem_busy, jmp, gnt, rv, rdy, e_req, e_grant, pop;
        logic [31:0] pc, mem_addr;
        int          mem_wait;
        i_reset_n = 0; i_pc_addr = 0; i_jump_flag = 0; i_mem_gnt = 0;
        i_mem_rvalid = 0; i_mem_rdata = 0; i_inst_ready = 0;
        step(); step();
        check_reset_outs("rst");

        // Streaming fetch: grant every other cycle, one-cycle response latency
        i_reset_n = 1; i_mem_gnt = 1; i_inst_ready = 1;
        for (int k = 0; k < 3; k++) begin
            i_pc_addr = 32'(4 * k);
            #1;
            check("str_req", 32'(o_mem_req), 32'd1);
            check("str_hold", 32'(o_hold_req), 32'd0);
            check("str_addr", o_mem_addr, 32'(4 * k));
            if (k > 0) begin
                check("str_iaddr", o_inst_addr, 32'(4 * (k - 1)));
                check("str_inst", o_inst, 32'hA0000000 + 32'(4 * (k - 1)));
            end
            step();
            i_pc_addr = 32'(4 * k + 4);
            i_mem_rvalid = 1; i_mem_rdata = 32'hA0000000 + 32'(4 * k);
            #1;
            check("str_wreq", 32'(o_mem_req), 32'd0);
            check("str_whold", 32'(o_hold_req), 32'd1);
            step();
            i_mem_rvalid = 0;
        end
        i_mem_gnt = 0;
        #1;
        check("str_lvalid", 32'(o_inst_valid), 32'd1);
        check("str_liaddr", o_inst_addr, 32'h8);
        check("str_linst", o_inst, 32'hA0000008);
        step();
        check("str_empty", 32'(o_inst_valid), 32'd0);

        // Fill the buffer with decode stalled
        i_reset_n = 0; step(); i_reset_n = 1;
        i_inst_ready = 0; i_mem_gnt = 1; i_pc_addr = 0;
        step();
        i_pc_addr = 4; i_mem_rvalid = 1; i_mem_rdata = 32'h11111111;
        step();
        i_mem_rvalid = 0;
        step();
        i_pc_addr = 8; i_mem_rvalid = 1; i_mem_rdata = 32'h22222222;
        step();
        i_mem_rvalid = 0;
        #1;
        check("full_req", 32'(o_mem_req), 32'd0);
        check("full_hold", 32'(o_hold_req), 32'd1);
        check("full_valid", 32'(o_inst_valid), 32'd1);
        check("full_inst", o_inst, 32'h11111111);
        check("full_iaddr", o_inst_addr, 32'h0);
        step();
        check("full_hold2", 32'(o_hold_req), 32'd1);
        check("full_inst2", o_inst, 32'h11111111);
        i_inst_ready = 1;
        step();
        i_inst_ready = 0;
        #1;
        check("pop_inst", o_inst, 32'h22222222);
        check("pop_iaddr", o_inst_addr, 32'h4);
        check("pop_req", 32'(o_mem_req), 32'd1);
        check("pop_hold", 32'(o_hold_req), 32'd0);
        check("pop_addr", o_mem_addr, 32'h8);
        step();
        i_pc_addr = 12;

        // Jump while the request at 0x8 is in flight
        i_mem_gnt = 0; i_jump_flag = 1;
        #1;
        check("jmp_req", 32'(o_mem_req), 32'd0);
        check("jmp_hold", 32'(o_hold_req), 32'd1);
        step();
        i_jump_flag = 0; i_pc_addr = 32'h100;
        #1;
        check("dis_valid", 32'(o_inst_valid), 32'd0);
        check("dis_req", 32'(o_mem_req), 32'd0);
        i_mem_rvalid = 1; i_mem_rdata = 32'hDEADBEEF;
        step();
        i_mem_rvalid = 0;
        #1;
        check("dis_drop", 32'(o_inst_valid), 32'd0);
        check("dis_inst", o_inst, 32'd0);
        check("tgt_req", 32'(o_mem_req), 32'd1);
        check("tgt_addr", o_mem_addr, 32'h100);
        i_mem_gnt = 1;
        step();
        i_mem_gnt = 0; i_pc_addr = 32'h104;
        i_mem_rvalid = 1; i_mem_rdata = 32'hCAFE0100;
        step();
        i_mem_rvalid = 0;
        #1;
        check("tgt_valid", 32'(o_inst_valid), 32'd1);
        check("tgt_iaddr", o_inst_addr, 32'h100);
        check("tgt_inst", o_inst, 32'hCAFE0100);

        // Jump coinciding with a response and a pop at count 1
        i_mem_gnt = 1;
        step();
        i_mem_gnt = 0; i_pc_addr = 32'h108;
        i_jump_flag = 1; i_mem_rvalid = 1; i_mem_rdata = 32'h33333333; i_inst_ready = 1;
        #1;
        check("coj_req", 32'(o_mem_req), 32'd0);
        check("coj_valid", 32'(o_inst_valid), 32'd1);
        step();
        i_jump_flag = 0; i_mem_rvalid = 0; i_inst_ready = 0; i_pc_addr = 32'h200;
        #1;
        check("coj_empty", 32'(o_inst_valid), 32'd0);
        check("coj_inst", o_inst, 32'd0);
        check("coj_idle", 32'(o_mem_req), 32'd1);

        // Reset while a request is outstanding, then a late response
        i_mem_gnt = 1;
        step();
        i_mem_gnt = 0; i_pc_addr = 32'h204; i_reset_n = 0;
        step();
        check_reset_outs("mrst");
        i_reset_n = 1; i_pc_addr = 0; i_mem_rvalid = 1; i_mem_rdata = 32'h44444444;
        #1;
        check("mrst_idle", 32'(o_mem_req), 32'd1);
        step();
        i_mem_rvalid = 0;
        check("mrst_ign", 32'(o_inst_valid), 32'd0);
        i_mem_gnt = 1;
        #1;
        check("mrst_hold", 32'(o_hold_req), 32'd0);
        check("mrst_addr", o_mem_addr, 32'h0);
        step();
        i_mem_gnt = 0; i_pc_addr = 4; i_mem_rvalid = 1; i_mem_rdata = 32'h55555555;
        step();
        i_mem_rvalid = 0;
        #1;
        check("mrst_valid", 32'(o_inst_valid), 32'd1);
        check("mrst_iaddr", o_inst_addr, 32'h0);
        check("mrst_inst", o_inst, 32'h55555555);

        // Randomized run against the reference model
        i_reset_n = 0; step(); i_reset_n = 1;
        m_out = 0; m_flush = 0; mem_busy = 0; mem_wait = 0; mem_addr = 0; pc = 0;
        for (int c = 0; c < 10000; c++) begin
            jmp = ($urandom % 16) == 0;
            gnt = ($urandom % 3) != 0;
            rdy = ($urandom % 2) != 0;
            if (mem_busy) begin
                rv = mem_wait == 0;
                i_mem_rdata = word(mem_addr);
            end else begin
                rv = ($urandom % 8) == 0;
                i_mem_rdata = $urandom;
            end
            i_jump_flag = jmp; i_mem_gnt = gnt; i_inst_ready = rdy;
            i_mem_rvalid = rv; i_pc_addr = pc;
            #1;
            e_req = !m_out && q.size() < DEPTH && !jmp;
            e_grant = e_req && gnt;
            check("rnd_req", 32'(o_mem_req), 32'(e_req));
            check("rnd_hold", 32'(o_hold_req), 32'(!e_grant));
            check("rnd_addr", o_mem_addr, pc);
            check("rnd_valid", 32'(o_inst_valid), 32'(q.size() != 0));
            check("rnd_inst", o_inst, q.size() != 0 ? q[0].d : 32'd0);
            check("rnd_iaddr", o_inst_addr, q.size() != 0 ? q[0].a : 32'd0);
            pop = q.size() != 0 && rdy;
            if (jmp) begin
                q.delete();
                if (m_out) begin
                    if (rv) m_out = 0;
                    else m_flush = 1;
                end
            end else begin
                if (pop) void'(q.pop_front());
                if (m_out && rv) begin
                    if (!m_flush) q.push_back('{a: mem_addr, d: word(mem_addr)});
                    m_out = 0;
                end
            end
            if (mem_busy) begin
                if (mem_wait == 0) mem_busy = 0;
                else mem_wait--;
            end
            if (e_grant) begin
                m_out = 1; m_flush = 0;
                mem_busy = 1; mem_wait = $urandom_range(0, 4); mem_addr = pc;
            end
            if (jmp) pc = $urandom & 32'h0000FFFC;
            else if (e_grant) pc = pc + 4;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
